// File: rtl/button_repeat_detect.sv
// Key event generator for N push-buttons: N-sample debounce, single-key and release
// qualification, optional typematic auto-repeat; one-clk event strobes with code and mask.
module button_repeat_detect #(
   parameter int N_BTN        = 5,
   parameter int CODE_W       = 4,
   parameter int DEBOUNCE     = 3,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BTN-1:0]  bt,
   input  logic              work1,
   input  logic              work0,
   output logic              ena,
   output logic [CODE_W-1:0] od,
   output logic [N_BTN-1:0]  bto,
   output logic              rep
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_REPEAT,
      ST_WAIT_REL
   } state_e;

   state_e                           state_q, state_d;
   logic [CODE_W-1:0]                key_q, key_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [DEBOUNCE-1:0][CODE_W-1:0]  hist_q, hist_d;
   logic                             ena_q, ena_d;
   logic [CODE_W-1:0]                od_q, od_d;
   logic [N_BTN-1:0]                 bto_q, bto_d;
   logic                             rep_q, rep_d;

   logic [CODE_W-1:0] sample_code;
   logic [CODE_W-1:0] hit_code;
   logic              hit_one;
   logic              hit_multi;
   logic              hist_flat;
   logic              stable_key;
   logic              stable_null;
   logic              fire;
   logic              fire_rep;

   // Exactly one pressed button yields its code; none or a chord yields NULL.
   // NOTE: combinational blocks use blocking '=' and assign every output a default
   // first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      hit_one   = 1'b0;
      hit_multi = 1'b0;
      hit_code  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (bt[i]) begin
            if (hit_one) begin
               hit_multi = 1'b1;
            end
            hit_one  = 1'b1;
            hit_code = CODE_W'(i + 1);
         end
      end
      sample_code = (hit_one && !hit_multi) ? hit_code : '0;
   end

   always_comb begin
      hist_d = hist_q;
      if (work1) begin
         hist_d = {hist_q[DEBOUNCE-2:0], sample_code};
      end
   end

   // Stability is judged on the history including the sample taken this tick.
   always_comb begin
      hist_flat = 1'b1;
      for (int k = 1; k < DEBOUNCE; k++) begin
         if (hist_d[k] != hist_d[0]) begin
            hist_flat = 1'b0;
         end
      end
      stable_key  = work1 && hist_flat && (hist_d[0] != '0);
      stable_null = work1 && hist_flat && (hist_d[0] == '0);
   end

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      cnt_d    = cnt_q;
      fire     = 1'b0;
      fire_rep = 1'b0;
      if (work1) begin
         case (state_q)
            ST_IDLE: begin
               if (stable_key) begin
                  state_d = ST_HELD;
                  key_d   = sample_code;
                  cnt_d   = '0;
                  fire    = 1'b1;
               end
            end
            ST_HELD: begin
               if (sample_code != key_q) begin
                  state_d = ST_WAIT_REL;
               end else if (REPEAT_EN != 0) begin
                  if (cnt_q == DELAY_LAST) begin
                     state_d  = ST_REPEAT;
                     cnt_d    = '0;
                     fire     = 1'b1;
                     fire_rep = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            end
            ST_REPEAT: begin
               if (sample_code != key_q) begin
                  state_d = ST_WAIT_REL;
               end else if (cnt_q == RATE_LAST) begin
                  cnt_d    = '0;
                  fire     = 1'b1;
                  fire_rep = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_WAIT_REL: begin
               // Any non-NULL sample, even a new key, keeps waiting for a clean release.
               if (stable_null) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Only the visible strobe is suppressed by work0; the FSM has already moved on.
   always_comb begin
      ena_d = fire && work0;
      od_d  = ena_d ? key_d : '0;
      rep_d = fire_rep;
      bto_d = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (ena_d && (key_d == CODE_W'(i + 1))) begin
            bto_d[i] = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         // NOTE: the history is a small flop array, not RAM, so it is cleared with
         // everything else; a stale sample could otherwise qualify a press after reset.
         hist_q  <= '0;
         ena_q   <= 1'b0;
         od_q    <= '0;
         bto_q   <= '0;
         rep_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         hist_q  <= hist_d;
         ena_q   <= ena_d;
         od_q    <= od_d;
         bto_q   <= bto_d;
         rep_q   <= rep_d;
      end
   end

   assign ena = ena_q;
   assign od  = od_q;
   assign bto = bto_q;
   assign rep = rep_q;

endmodule

// File: tb/tb_button_repeat_detect.sv
// Self-checking bench for button_repeat_detect: table-driven tick vectors with a
// per-clock expected-output queue, plus hand-written reset and continuous-tick sequences.
module tb_button_repeat_detect;

   typedef struct {
      logic [4:0] bt;
      logic       w0;
      logic       ena;
      logic [3:0] od;
      logic [4:0] bto;
      logic       rep;
   } vec_t;

   typedef struct {
      logic       ena;
      logic [3:0] od;
      logic [4:0] bto;
      logic       rep;
      int         idx;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [4:0] bt;
   logic       work1;
   logic       work0;
   logic       sel_nr;

   logic       ena_a, rep_a, ena_b, rep_b;
   logic [3:0] od_a, od_b;
   logic [4:0] bto_a, bto_b;

   logic       ena, rep;
   logic [3:0] od;
   logic [4:0] bto;

   exp_t exp_q[$];
   vec_t vecs[$];
   vec_t vecs_nr[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_miss = 0;

   assign ena = sel_nr ? ena_b : ena_a;
   assign od  = sel_nr ? od_b  : od_a;
   assign bto = sel_nr ? bto_b : bto_a;
   assign rep = sel_nr ? rep_b : rep_a;

   button_repeat_detect #(
      .N_BTN(5), .CODE_W(4), .DEBOUNCE(3),
      .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut (
      .clk(clk), .rst(rst), .bt(bt), .work1(work1), .work0(work0),
      .ena(ena_a), .od(od_a), .bto(bto_a), .rep(rep_a)
   );

   button_repeat_detect #(
      .N_BTN(5), .CODE_W(4), .DEBOUNCE(3),
      .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut_nr (
      .clk(clk), .rst(rst), .bt(bt), .work1(work1), .work0(work0),
      .ena(ena_b), .od(od_b), .bto(bto_b), .rep(rep_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at time limit, want completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] b, input logic w0,
                               input logic [3:0] ev_od, input logic ev_rep);
      vec_t v;
      v.bt  = b;
      v.w0  = w0;
      v.ena = (ev_od != 4'd0);
      v.od  = ev_od;
      v.bto = (ev_od != 4'd0) ? 5'(32'd1 << (ev_od - 4'd1)) : 5'd0;
      v.rep = ev_rep;
      return v;
   endfunction

   task automatic add(input bit nr, input vec_t v);
      if (nr) vecs_nr.push_back(v);
      else    vecs.push_back(v);
   endtask

   task automatic hold(input bit nr, input logic [4:0] b, input int n);
      for (int i = 0; i < n; i++) add(nr, mk(b, 1'b1, 4'd0, 1'b0));
   endtask

   // One work1 tick, then 'gap' quiet clocks; one expected record per clock.
   task automatic tick(input vec_t v, input int idx, input int gap);
      exp_t e;
      @(negedge clk);
      bt    = v.bt;
      work0 = v.w0;
      work1 = 1'b1;
      e.ena = v.ena; e.od = v.od; e.bto = v.bto; e.rep = v.rep; e.idx = idx;
      exp_q.push_back(e);
      e.ena = 1'b0; e.od = 4'd0; e.bto = 5'd0; e.rep = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         work1 = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      work1 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("queue_drain", 16'(exp_q.size()), 16'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check($sformatf("vec%0d_event", mon_e.idx), {6'b0, ena, od, bto},
               {6'b0, mon_e.ena, mon_e.od, mon_e.bto});
         if (mon_e.ena) begin
            check($sformatf("vec%0d_rep", mon_e.idx), {15'b0, rep}, {15'b0, mon_e.rep});
         end
      end
   end

   initial begin
      rst    = 1'b1;
      bt     = 5'b0;
      work1  = 1'b0;
      work0  = 1'b1;
      sel_nr = 1'b0;

      // Hold key 2 for 12 ticks: first press at tick 3, repeats at 7, 9, 11.
      hold(0, 5'b00010, 2);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b0));
      hold(0, 5'b00010, 3);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b1));
      hold(0, 5'b00010, 1);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b1));
      hold(0, 5'b00010, 1);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b1));
      hold(0, 5'b00010, 1);
      // Release, bounce, release, then key 5.
      hold(0, 5'b00000, 3);
      hold(0, 5'b00010, 1);
      hold(0, 5'b00000, 1);
      hold(0, 5'b00010, 2);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b0));
      hold(0, 5'b00000, 3);
      hold(0, 5'b10000, 2);
      add(0, mk(5'b10000, 1'b1, 4'd5, 1'b0));
      // Chord never fires; chord mid-repeat ends the press; new key needs a release.
      hold(0, 5'b00011, 10);
      hold(0, 5'b00010, 2);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b0));
      hold(0, 5'b00010, 3);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b1));
      hold(0, 5'b00110, 1);
      hold(0, 5'b00100, 6);
      hold(0, 5'b00000, 3);
      hold(0, 5'b00100, 2);
      add(0, mk(5'b00100, 1'b1, 4'd3, 1'b0));
      hold(0, 5'b00000, 3);
      // work0 low on the press tick: no event, repeat still on schedule, no catch-up.
      hold(0, 5'b00010, 2);
      add(0, mk(5'b00010, 1'b0, 4'd0, 1'b0));
      hold(0, 5'b00010, 3);
      add(0, mk(5'b00010, 1'b1, 4'd2, 1'b1));
      hold(0, 5'b00010, 1);
      hold(0, 5'b00000, 3);

      // Auto-repeat disabled: one event per press.
      hold(1, 5'b00001, 2);
      add(1, mk(5'b00001, 1'b1, 4'd1, 1'b0));
      hold(1, 5'b00001, 17);
      hold(1, 5'b00000, 3);
      hold(1, 5'b00001, 2);
      add(1, mk(5'b00001, 1'b1, 4'd1, 1'b0));
      hold(1, 5'b00000, 3);

      repeat (2) @(negedge clk);
      check("reset_state", {5'b0, ena, od, bto, rep}, 16'd0);
      rst = 1'b0;

      // Async reset while the first-press strobe is high.
      bt = 5'b00010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         work1 = 1'b1;
         @(negedge clk);
         work1 = 1'b0;
      end
      check("pre_rst_event", {5'b0, ena, od, bto, rep}, {5'b0, 1'b1, 4'd2, 5'b00010, 1'b0});
      #2 rst = 1'b1;
      #1 check("rst_async_clear", {5'b0, ena, od, bto, rep}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) tick(vecs[i], i, 3);
      drain();

      sel_nr = 1'b1;
      for (int i = 0; i < vecs_nr.size(); i++) tick(vecs_nr[i], 1000 + i, 3);
      drain();
      sel_nr = 1'b0;

      // work1 high every clock: release, press key 3, strobe still one clock wide.
      tick(mk(5'b00000, 1'b1, 4'd0, 1'b0), 2000, 0);
      tick(mk(5'b00000, 1'b1, 4'd0, 1'b0), 2001, 0);
      tick(mk(5'b00000, 1'b1, 4'd0, 1'b0), 2002, 0);
      tick(mk(5'b00100, 1'b1, 4'd0, 1'b0), 2003, 0);
      tick(mk(5'b00100, 1'b1, 4'd0, 1'b0), 2004, 0);
      tick(mk(5'b00100, 1'b1, 4'd3, 1'b0), 2005, 0);
      tick(mk(5'b00100, 1'b1, 4'd0, 1'b0), 2006, 3);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/button_repeat_detect.md
# button_repeat_detect

Parametrised front-panel key event generator for N push-buttons, sampled on a slow enable tick. It provides N-sample debounce, single-key qualification, release qualification and optional typematic auto-repeat. One-cycle event pulses carry a key code and one-hot mask. It sits between the raw board buttons and the game-control FSM, replacing the fixed 5-button, 2-sample edge detector.

## Interface
Parameters:
- N_BTN, 5: number of buttons; legal range 2..15.
- CODE_W, 4: key code width; must satisfy 2^CODE_W > N_BTN.
- DEBOUNCE, 3: consecutive identical samples needed to qualify a press or a release; legal range 2..8.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives one event per press.
- REPEAT_DELAY, 16: ticks from the first event to the first repeat; must be ≥1.
- REPEAT_RATE, 4: ticks between subsequent repeats; must be ≥1.

Ports:
- clk, in, 1: system clock; all registers are on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- bt, in, N_BTN: raw button levels, active high; bt[i] is button i.
- work1, in, 1: sample tick; one-clk pulse (for example ~1 kHz). Logic advances only on edges where work1=1.
- work0, in, 1: output enable. An event whose deciding tick has work0=0 is discarded, not queued.
- ena, out, 1: event strobe, high for exactly one clk cycle.
- od, out, CODE_W: key code (i+1 for button i), valid with ena; 0 otherwise.
- bto, out, N_BTN: one-hot button mask, valid with ena; 0 otherwise.
- rep, out, 1: 1 marks an auto-repeat event, 0 a first press; valid with ena.

## Operation
- Sample decode:
  - code = i+1 when bt has exactly bit i set.
  - code = 0 (NULL) when no bit or more than one bit is set.
- History: shift register of DEBOUNCE codes. It shifts the new code in on every work1 edge.
- Stable(c): every history entry equals c, including the sample just taken. The FSM evaluates stability on the same work1 edge, using the updated history.
- FSM states:
  - IDLE → HELD when Stable(c) with c≠0. Latch key=c, cnt=0, fire event (rep=0).
  - HELD, on a tick where sample==key:
    - If REPEAT_EN=1 and cnt+1==REPEAT_DELAY: fire event (rep=1), cnt=0, go to REPEAT.
    - Otherwise: cnt++.
  - HELD, on a tick where sample≠key: go to WAIT_REL.
  - REPEAT, on a tick where sample==key:
    - If cnt+1==REPEAT_RATE: fire event (rep=1), cnt=0.
    - Otherwise: cnt++.
  - REPEAT, on a tick where sample≠key: go to WAIT_REL.
  - WAIT_REL → IDLE only when Stable(0). Any non-NULL sample keeps the FSM in WAIT_REL. A different key therefore needs a full release before it can be recognised.
- Fire event: register ena=work0, od=work0?key:0, bto=work0?onehot(key):0, rep. Only these output registers are gated by work0; history, FSM and cnt advance regardless.
- cnt width: $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1). cnt never exceeds its limit-1.
- ena, od, bto and rep return to 0 on the next clk edge, whether or not work1 is high.
- Multi-key chords never produce events. A chord during HELD or REPEAT ends the press and moves the FSM to WAIT_REL.

## Timing
- Reset: immediately on rst rise, independent of clk.
  - ena=0, od=0, bto=0, rep=0.
  - State=IDLE, cnt=0, key=0, history all NULL.
- After rst falls, the first work1 edge samples normally.
- First-press latency: ena is high in the clk cycle after the DEBOUNCE-th consecutive matching work1 edge.
- Repeat timing:
  - First repeat: REPEAT_DELAY ticks after the first-press tick.
  - Subsequent repeats: every REPEAT_RATE ticks.
- Minimum release-to-next-press spacing: DEBOUNCE NULL ticks plus DEBOUNCE press ticks.
- An async rst mid-repeat or mid-event clears the pending strobe. No event resumes; a fresh debounce is required.
- work1 held high continuously is legal: ticks become every clk cycle, and ena is still one cycle per event.

## Test plan
Defaults: N_BTN=5, CODE_W=4, DEBOUNCE=3, REPEAT_DELAY=4, REPEAT_RATE=2, work1 every 4th clk, work0=1.
1. Reset: assert rst mid-cycle with bt=00010 → all outputs are 0 asynchronously. After release, no event before 3 ticks.
2. Hold bt=00010 for 12 ticks:
   - Event at tick 3: od=2, bto=00010, rep=0.
   - Repeats at ticks 7, 9 and 11: rep=1, od=2.
   - ena is exactly one clk wide each time.
3. Bounce sequence 00010, 00000, 00010, 00010, 00010 → single event after the 5th tick. Then release with 3 NULL ticks and press 10000 for 3 ticks → od=5, bto=10000.
4. Chord 00011 held 10 ticks → no event. Holding 00010 and adding 00100 mid-repeat → repeats stop, and there is no event for 00100 until a 3-tick release.
5. work0=0 during tick 3 of a press → no event. work0=1 at tick 7 → repeat fires with rep=1, and no catch-up event occurs.
6. REPEAT_EN=0: hold 00001 for 20 ticks → exactly one event (od=1). Release 3 ticks and press again → second event.
